// File: rtl/pu_seq_ctrl.sv
// pu_seq_ctrl: issues buffer reads for an N-group dot product and accumulates PU sums with saturation.
module pu_seq_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int ACC_W   = 16,
  parameter int MEM_LAT = 1,
  parameter int PU_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_groups,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [11:0]       pu_sum,
  output logic              rd_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic              ovf
);
  localparam int L = MEM_LAT + PU_LAT;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d, ib_q, ib_d, wb_q, wb_d, idx_q, idx_d;
  logic [L-1:0] vp_q, vp_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic [ACC_W:0] sum;
  always_comb begin
    rd_en = state_q == ISSUE;
    busy = state_q != IDLE;
    result_valid = state_q == DONE;
    vp_d = (vp_q << 1) | L'(rd_en);
    sum = {1'b0, acc_q} + (ACC_W+1)'(pu_sum);
    state_d = state_q;
    n_d = n_q;
    ib_d = ib_q;
    wb_d = wb_q;
    idx_d = idx_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    // the last tap lines up with the PU output for the group issued L cycles earlier
    if (vp_q[L-1]) begin
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
    case (state_q)
      IDLE: if (start) begin
        n_d = num_groups;
        ib_d = in_base;
        wb_d = w_base;
        idx_d = '0;
        acc_d = '0;
        ovf_d = 1'b0;
        state_d = (num_groups == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        idx_d = (idx_q == n_q - 1'b1) ? '0 : idx_q + 1'b1;
        state_d = (idx_q == n_q - 1'b1) ? DRAIN : ISSUE;
      end
      DRAIN: state_d = (vp_d == '0) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      ib_q <= '0;
      wb_q <= '0;
      idx_q <= '0;
      vp_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      ib_q <= ib_d;
      wb_q <= wb_d;
      idx_q <= idx_d;
      vp_q <= vp_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_addr = ib_q + idx_q;
  assign w_addr = wb_q + idx_q;
  assign result = acc_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pu_seq_ctrl.sv
// tb_pu_seq_ctrl: directed tests with a bench-side PU/buffer latency model feeding pu_sum.
module tb_pu_seq_ctrl;
  logic clk = 0, rst = 0, start = 0;
  logic [5:0] num_groups = 0, in_base = 0, w_base = 0;
  logic [11:0] pu_sum;
  logic rd_en, busy, result_valid, ovf;
  logic [5:0] in_addr, w_addr;
  logic [15:0] result;
  int n_cmp = 0, n_err = 0;
  logic [11:0] tbl [64];
  logic [2:0] mv;
  logic [5:0] ma [3];
  int rd_c[$];
  logic [5:0] ia_q[$], wa_q[$];
  int vcyc, busy_cyc;
  logic [15:0] vres;
  logic vovf, busy_after;

  pu_seq_ctrl dut (.clk(clk), .rst(rst), .start(start), .num_groups(num_groups), .in_base(in_base),
    .w_base(w_base), .pu_sum(pu_sum), .rd_en(rd_en), .in_addr(in_addr), .w_addr(w_addr), .busy(busy),
    .result(result), .result_valid(result_valid), .ovf(ovf));

  always #5 clk = ~clk;

  // buffer (1 cycle) + PU (2 cycles); garbage when nothing valid is in flight
  always @(posedge clk or posedge rst) begin
    if (rst) mv <= '0;
    else begin
      mv <= {mv[1:0], rd_en};
      ma[0] <= in_addr;
      ma[1] <= ma[0];
      ma[2] <= ma[1];
    end
  end
  assign pu_sum = mv[2] ? tbl[ma[2]] : 12'hFFF;

  task automatic run_job(input logic [5:0] n, input logic [5:0] ib, input logic [5:0] wb, input int xcyc);
    rd_c.delete(); ia_q.delete(); wa_q.delete();
    vcyc = 0; busy_cyc = 0;
    @(negedge clk);
    num_groups = n; in_base = ib; w_base = wb; start = 1;
    for (int c = 1; c <= 80 && vcyc == 0; c++) begin
      @(posedge clk); #1;
      if (busy) busy_cyc++;
      if (rd_en) begin rd_c.push_back(c); ia_q.push_back(in_addr); wa_q.push_back(w_addr); end
      if (result_valid) begin vcyc = c; vres = result; vovf = ovf; end
      start = (c == xcyc);
      if (start) num_groups = 6'd1;
    end
    start = 0;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1; #1;
    n_cmp++; if ({busy, rd_en, result_valid, ovf, result, in_addr, w_addr} !== 35'd0) begin n_err++;
      $display("FAIL reset: outputs=%h want 0", {busy, rd_en, result_valid, ovf, result, in_addr, w_addr}); end
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic test_single;
    tbl[0] = 12'(1*5 + 2*6 + 3*7 + 4*8);
    run_job(1, 0, 0, 0);
    n_cmp++; if (rd_c.size() != 1 || rd_c[0] != 1) begin n_err++; $display("FAIL single_rd: count=%0d want 1 at cycle 1", rd_c.size()); end
    n_cmp++; if (vcyc != 5) begin n_err++; $display("FAIL single_vcyc: got %0d want 5", vcyc); end
    n_cmp++; if (vres !== 16'd70) begin n_err++; $display("FAIL single_result: got %0d want 70", vres); end
    n_cmp++; if (vovf !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", vovf); end
    n_cmp++; if (busy_after !== 1'b0 || result !== 16'd70) begin n_err++;
      $display("FAIL single_idle: busy=%b result=%0d want 0/70", busy_after, result); end
  endtask

  task automatic test_three;
    tbl[0] = 70; tbl[1] = 3844; tbl[2] = 10;
    run_job(3, 0, 0, 0);
    n_cmp++; if (rd_c.size() != 3) begin n_err++; $display("FAIL three_rdcnt: got %0d want 3", rd_c.size()); end
    for (int i = 0; i < rd_c.size() && i < 3; i++) begin
      n_cmp++; if (rd_c[i] != i + 1 || ia_q[i] !== 6'(i)) begin n_err++;
        $display("FAIL three_issue[%0d]: cycle=%0d in_addr=%0d want %0d/%0d", i, rd_c[i], ia_q[i], i + 1, i); end
    end
    n_cmp++; if (vcyc != 7 || vres !== 16'd3924) begin n_err++;
      $display("FAIL three_result: cycle=%0d result=%0d want 7/3924", vcyc, vres); end
  endtask

  task automatic test_zero;
    tbl[0] = 12'd99;
    run_job(0, 0, 0, 0);
    n_cmp++; if (rd_c.size() != 0) begin n_err++; $display("FAIL zero_rd: got %0d reads want 0", rd_c.size()); end
    n_cmp++; if (vcyc != 1 || vres !== 16'd0) begin n_err++;
      $display("FAIL zero_result: cycle=%0d result=%0d want 1/0", vcyc, vres); end
    n_cmp++; if (busy_cyc != 1 || busy_after !== 1'b0) begin n_err++;
      $display("FAIL zero_busy: cycles=%0d after=%b want 1/0", busy_cyc, busy_after); end
  endtask

  task automatic test_wrap_ignore;
    tbl[62] = 1; tbl[63] = 2; tbl[0] = 3; tbl[1] = 4;
    run_job(4, 62, 10, 2);
    n_cmp++; if (rd_c.size() != 4) begin n_err++; $display("FAIL wrap_rdcnt: got %0d want 4", rd_c.size()); end
    for (int i = 0; i < rd_c.size() && i < 4; i++) begin
      n_cmp++; if (ia_q[i] !== 6'(62 + i) || wa_q[i] !== 6'(10 + i)) begin n_err++;
        $display("FAIL wrap_addr[%0d]: in=%0d w=%0d want %0d/%0d", i, ia_q[i], wa_q[i], 6'(62 + i), 10 + i); end
    end
    n_cmp++; if (vcyc != 8 || vres !== 16'd10) begin n_err++;
      $display("FAIL wrap_result: cycle=%0d result=%0d want 8/10", vcyc, vres); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 64; i++) tbl[i] = 12'd3844;
    run_job(20, 0, 0, 0);
    n_cmp++; if (vcyc != 24 || vres !== 16'hFFFF || vovf !== 1'b1) begin n_err++;
      $display("FAIL sat_result: cycle=%0d result=%0d ovf=%b want 24/65535/1", vcyc, vres, vovf); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL sat_sticky: ovf=%b want 1", ovf); end
    tbl[0] = 5;
    run_job(1, 0, 0, 0);
    n_cmp++; if (vres !== 16'd5 || vovf !== 1'b0) begin n_err++;
      $display("FAIL sat_next: result=%0d ovf=%b want 5/0", vres, vovf); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    tbl[0] = 70;
    @(negedge clk);
    num_groups = 5; in_base = 0; w_base = 0; start = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    rst = 1; #1;
    n_cmp++; if (busy !== 1'b0 || rd_en !== 1'b0 || result !== 16'd0) begin n_err++;
      $display("FAIL rstmid_outs: busy=%b rd_en=%b result=%0d want 0/0/0", busy, rd_en, result); end
    @(negedge clk); rst = 0;
    for (int c = 0; c < 12; c++) begin @(posedge clk); #1; if (result_valid || busy) pulses++; end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_quiet: %0d active cycles want 0", pulses); end
    run_job(1, 0, 0, 0);
    n_cmp++; if (vcyc != 5 || vres !== 16'd70 || vovf !== 1'b0) begin n_err++;
      $display("FAIL rstmid_restart: cycle=%0d result=%0d ovf=%b want 5/70/0", vcyc, vres, vovf); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tbl[i] = 0;
    test_reset();
    test_single();
    test_three();
    test_zero();
    test_wrap_ignore();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pu_seq_ctrl.md
Name: pu_seq_ctrl

Overview:
- Sequencer that drives the 4-lane multiply/add-tree processing unit (PU) through an N-group dot product.
- Issues synchronous-read addresses to the input and weight buffers, one 4-element group per cycle.
- Tracks memory and PU pipeline latency with a valid shift register and accumulates each 12-bit PU sum into a wide saturating accumulator.
- Reports the final result with a one-cycle valid pulse. Sits between the top-level control FSM and the PU and buffers.

Parameters:
- ADDR_W, 6, width of group addresses and of the group count.
- ACC_W, 16, accumulator/result width (must be >= 12).
- MEM_LAT, 1, buffer read latency in cycles (rd_en cycle to data at PU inputs).
- PU_LAT, 2, PU latency in cycles (operands at PU inputs to valid pu_sum).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin job; sampled only in IDLE.
- num_groups  in  ADDR_W  number of 4-element groups N; latched on accepted start.
- in_base  in  ADDR_W  first input-buffer group address; latched on start.
- w_base  in  ADDR_W  first weight-buffer group address; latched on start.
- pu_sum  in  12  registered sum from the PU.
- rd_en  out  1  buffer read strobe, one group per cycle.
- in_addr  out  ADDR_W  input-buffer group address.
- w_addr  out  ADDR_W  weight-buffer group address.
- busy  out  1  high whenever state != IDLE.
- result  out  ACC_W  accumulated dot product; held until the next accepted start.
- result_valid  out  1  one-cycle pulse when result is final.
- ovf  out  1  sticky saturation flag for the current job.

Behaviour:
- Reset (async, any state): state=IDLE. rd_en, busy, result_valid, ovf, result, in_addr, w_addr, group index, and valid pipe all go to 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and num_groups!=0: latch N and both bases, clear acc and ovf, go to ISSUE.
  - start=1 and num_groups==0: clear acc and ovf, go to DONE (result=0).
- ISSUE:
  - rd_en=1 every cycle.
  - in_addr = in_base+idx and w_addr = w_base+idx, both mod 2^ADDR_W (wrap-around is legal).
  - idx counts 0..N-1. When idx==N-1, go to DRAIN.
  - Exactly N rd_en cycles per job.
- Valid pipe: shift register of depth L=MEM_LAT+PU_LAT, input rd_en.
  - When tap L-1 is set, acc <= sat(acc + zero-extended pu_sum).
  - pu_sum is ignored when the tap is clear; the PU always computes, so garbage values appear there.
- DRAIN: rd_en=0. Leave to DONE on the cycle the valid pipe is all-zero after the last accumulate.
- DONE: result_valid=1 for exactly one cycle, then return to IDLE. busy deasserts in that following cycle.
- Timing (defaults), with the accepting start edge ending cycle 0:
  - rd_en is high in cycles 1..N.
  - The group issued in cycle c has pu_sum valid in cycle c+3 and is accumulated at the end of c+3.
  - result_valid is in cycle N+4.
  - N=0: result_valid in cycle 1.
- Arithmetic: unsigned. If acc + pu_sum > 2^ACC_W-1, acc = 2^ACC_W-1 and ovf=1. ovf stays set until the next accepted start.
- start while busy: ignored, with no effect on latched values.
- result is visible in every cycle, but is final only when result_valid=1 and stays stable in IDLE.
- Reset mid-job: the job is abandoned and nothing is pulsed. The PU shares rst, so no stale sums survive.

Test Plan:
- Single group: N=1, in_base=0, w_base=0, buffer returns inputs {1,2,3,4} and weights {5,6,7,8} so pu_sum=70 → rd_en in cycle 1 only; result=70 and result_valid in cycle 5; ovf=0.
- Three groups: N=3 with group sums 70, 3844, 10 → rd_en cycles 1–3; in_addr 0,1,2; result=3924 at cycle 7.
- Zero length: start with num_groups=0 → no rd_en; result=0 and result_valid in cycle 1; busy high for cycle 1 only.
- Wrap and ignored start:
  - N=4, in_base=62, w_base=10 → in_addr 62,63,0,1 and w_addr 10..13.
  - A second start pulsed in cycle 2 with num_groups=1 → ignored; result covers 4 groups.
- Saturation: N=20, every pu_sum=3844 (sum 76880) → result=65535, ovf=1. The next job (N=1, sum 5) → result=5, ovf=0.
- Async reset mid-ISSUE: assert rst in cycle 2 of an N=5 job → same-cycle busy=0, rd_en=0, result=0; no result_valid. A new start after release works normally.
